// File: rtl/nibble_serial_adder_pkg.sv
// Shared types and constants for the nibble-serial adder.
// FSM state encoding and the per-step digit width.
package nibble_serial_adder_pkg;

  localparam int NIBBLE_W = 4;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_e;

endpackage

// File: rtl/nibble_serial_adder_rca.sv
// ripple_carry_adder_4bit: one-nibble ripple-carry adder,
// the per-cycle datapath of nibble_serial_adder.
module ripple_carry_adder_4bit
  import nibble_serial_adder_pkg::*;
(
  input  logic [NIBBLE_W-1:0] a,
  input  logic [NIBBLE_W-1:0] b,
  input  logic                cin,
  output logic [NIBBLE_W-1:0] sum,
  output logic                carry
);

  logic [NIBBLE_W:0] c;

  always_comb begin
    c    = '0;
    sum  = '0;
    c[0] = cin;
    for (int i = 0; i < NIBBLE_W; i++) begin
      sum[i]   = a[i] ^ b[i] ^ c[i];
      c[i+1]   = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
  end

  assign carry = c[NIBBLE_W];

endmodule

// File: rtl/nibble_serial_adder.sv
// Nibble-serial unsigned adder with valid/ready handshakes.
// Define NIBBLE_SERIAL_ADDER_OVF_EN to add the signed-overflow output ovf.
module nibble_serial_adder
  import nibble_serial_adder_pkg::*;
#(
  parameter int NIBBLES = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NIBBLE_W*NIBBLES-1:0] a,
  input  logic [NIBBLE_W*NIBBLES-1:0] b,
  input  logic                    cin,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic [NIBBLE_W*NIBBLES-1:0] sum,
  output logic                    carry,
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
  output logic                    ovf,
`endif
  output logic                    out_valid,
  input  logic                    out_ready
);

  localparam int W     = NIBBLE_W * NIBBLES;
  localparam int IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NIBBLES - 1);

  state_e           state_q, state_d;
  logic [W-1:0]     a_q, a_d;
  logic [W-1:0]     b_q, b_d;
  logic [W-1:0]     sum_q, sum_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             c_q, c_d;
  logic             carry_q, carry_d;
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
  logic             ovf_q, ovf_d;
`endif

  logic [NIBBLE_W-1:0] nib_sum;
  logic                nib_carry;

  ripple_carry_adder_4bit u_rca (
    .a     (a_q[NIBBLE_W-1:0]),
    .b     (b_q[NIBBLE_W-1:0]),
    .cin   (c_q),
    .sum   (nib_sum),
    .carry (nib_carry)
  );

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    idx_d   = idx_q;
    c_d     = c_q;
    carry_d = carry_q;
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
    ovf_d   = ovf_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = b;
          c_d     = cin;
          idx_d   = '0;
          sum_d   = '0;
          carry_d = 1'b0;
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
          ovf_d   = 1'b0;
`endif
          state_d = BUSY;
        end
      end
      BUSY: begin
        a_d = a_q >> NIBBLE_W;
        b_d = b_q >> NIBBLE_W;
        c_d = nib_carry;
        for (int i = 0; i < NIBBLES; i++) begin
          if (idx_q == IDX_W'(i)) begin
            sum_d[i*NIBBLE_W +: NIBBLE_W] = nib_sum;
          end
        end
        if (idx_q == IDX_LAST) begin
          carry_d = nib_carry;
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
          // Same-sign operands giving an opposite-sign result.
          ovf_d   = ~(a_q[NIBBLE_W-1] ^ b_q[NIBBLE_W-1])
                  & (nib_sum[NIBBLE_W-1] ^ a_q[NIBBLE_W-1]);
`endif
          state_d = DONE;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      idx_q   <= '0;
      c_q     <= 1'b0;
      carry_q <= 1'b0;
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      idx_q   <= idx_d;
      c_q     <= c_d;
      carry_q <= carry_d;
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign sum       = sum_q;
  assign carry     = carry_q;
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
  assign ovf       = ovf_q;
`endif

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Self-checking bench for nibble_serial_adder (NIBBLES=4),
// random operands against an arithmetic reference model.
module tb_nibble_serial_adder;

  localparam int N = 4;
  localparam int W = 4 * N;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         cin = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] sum;
  logic         carry;
  logic         out_valid;
  logic         out_ready = 1'b0;
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
  logic         ovf;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  int           lat;
  logic [W-1:0] obs_sum;
  logic         obs_carry;
  logic         obs_ovf;
  logic [W-1:0] obs_part [N];

  nibble_serial_adder #(.NIBBLES(N)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .sum       (sum),
    .carry     (carry),
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
    .ovf       (ovf),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  function automatic logic [W:0] ref_add(input logic [W-1:0] x,
                                         input logic [W-1:0] y,
                                         input logic ci);
    return {1'b0, x} + {1'b0, y} + {{W{1'b0}}, ci};
  endfunction

  function automatic logic ref_ovf(input logic [W-1:0] x,
                                   input logic [W-1:0] y,
                                   input logic ci);
    int s;
    s = int'($signed(x)) + int'($signed(y)) + int'(ci);
    return (s > 32767) || (s < -32768);
  endfunction

  function automatic logic [W-1:0] low_mask(input int nibs);
    logic [W:0] m;
    m = ({{W{1'b0}}, 1'b1} << (4 * nibs)) - 1'b1;
    return m[W-1:0];
  endfunction

  // Drive one operation from a negedge in IDLE; stop in DONE.
  task automatic run_op(input logic [W-1:0] x, input logic [W-1:0] y,
                        input logic ci);
    a = x;
    b = y;
    cin = ci;
    in_valid = 1'b1;
    lat = -1;
    for (int i = 0; i < N; i++) obs_part[i] = 'x;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      in_valid = 1'b0;
      if (out_valid) begin
        lat = i;
        break;
      end
      if (i <= N) obs_part[i-1] = sum;
    end
    obs_sum = sum;
    obs_carry = carry;
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
    obs_ovf = ovf;
`else
    obs_ovf = 1'b0;
`endif
  endtask

  task automatic finish_op();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    #1;
    n_cmp++;
    if (sum !== '0) begin
      n_bad++; $display("FAIL rst_sum got %h want 0", sum);
    end
    n_cmp++;
    if (carry !== 1'b0) begin
      n_bad++; $display("FAIL rst_carry got %b want 0", carry);
    end
    n_cmp++;
    if (out_valid !== 1'b0) begin
      n_bad++; $display("FAIL rst_out_valid got %b want 0", out_valid);
    end
    n_cmp++;
    if (in_ready !== 1'b1) begin
      n_bad++; $display("FAIL rst_in_ready got %b want 1", in_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
    // Handshake on the very first edge after release.
    run_op(16'h0001, 16'h0002, 1'b0);
    n_cmp++;
    if (lat != N + 1) begin
      n_bad++; $display("FAIL first_latency got %0d want %0d", lat, N + 1);
    end
    n_cmp++;
    if ({obs_carry, obs_sum} !== 17'h00003) begin
      n_bad++; $display("FAIL basic_sum got %h want 00003", {obs_carry, obs_sum});
    end
    finish_op();
  endtask

  task automatic test_ripple();
    run_op(16'hFFFF, 16'h0000, 1'b1);
    n_cmp++;
    if ({obs_carry, obs_sum} !== 17'h10000) begin
      n_bad++; $display("FAIL ripple_sum got %h want 10000", {obs_carry, obs_sum});
    end
    n_cmp++;
    if (lat != N + 1) begin
      n_bad++; $display("FAIL ripple_latency got %0d want %0d", lat, N + 1);
    end
    for (int i = 0; i < N; i++) begin
      n_cmp++;
      if (obs_part[i] !== '0) begin
        n_bad++; $display("FAIL ripple_part%0d got %h want 0", i, obs_part[i]);
      end
    end
    finish_op();
  endtask

  task automatic test_hold_and_ignore();
    logic [W-1:0] x, y;
    logic [W:0]   exp;
    int           l;
    x = W'($urandom);
    y = W'($urandom);
    exp = ref_add(x, y, 1'b0);
    a = x; b = y; cin = 1'b0; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    in_valid = 1'b1;
    a = ~x; b = ~y; cin = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    out_ready = 1'b0;
    l = 3;
    while (!out_valid && l < 20) begin
      @(negedge clk);
      l++;
    end
    n_cmp++;
    if (l != N + 1) begin
      n_bad++; $display("FAIL hold_latency got %0d want %0d", l, N + 1);
    end
    n_cmp++;
    if ({carry, sum} !== exp) begin
      n_bad++; $display("FAIL hold_result got %h want %h", {carry, sum}, exp);
    end
    for (int i = 0; i < 10; i++) begin
      in_valid = i[0];
      a = W'($urandom);
      @(negedge clk);
      n_cmp++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || {carry, sum} !== exp) begin
        n_bad++;
        $display("FAIL hold_cyc%0d got v=%b r=%b %h want v=1 r=0 %h",
                 i, out_valid, in_ready, {carry, sum}, exp);
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] x, y;
    logic [W:0]   exp;
    // Output handshake with in_valid already high: it must be ignored.
    in_valid = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    n_cmp++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL b2b_idle got v=%b r=%b want v=0 r=1", out_valid, in_ready);
    end
    x = W'($urandom);
    y = W'($urandom);
    exp = ref_add(x, y, 1'b1);
    run_op(x, y, 1'b1);
    n_cmp++;
    if (lat != N + 1 || {obs_carry, obs_sum} !== exp) begin
      n_bad++;
      $display("FAIL b2b_op got lat=%0d %h want lat=%0d %h",
               lat, {obs_carry, obs_sum}, N + 1, exp);
    end
    finish_op();
  endtask

  task automatic test_reset_abort();
    logic seen;
    a = 16'h1234; b = W'($urandom); cin = 1'b0; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (sum !== '0 || carry !== 1'b0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL abort_rst got s=%h c=%b v=%b r=%b want s=0 c=0 v=0 r=1",
               sum, carry, out_valid, in_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    n_cmp++;
    if (seen !== 1'b0 || in_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL abort_no_result got seen=%b r=%b want seen=0 r=1", seen, in_ready);
    end
  endtask

  task automatic check_one(input logic [W-1:0] x, input logic [W-1:0] y,
                           input logic ci);
    logic [W:0] exp;
    logic [W-1:0] pe;
    exp = ref_add(x, y, ci);
    run_op(x, y, ci);
    n_cmp++;
    if (lat != N + 1) begin
      n_bad++; $display("FAIL rnd_latency %h+%h got %0d want %0d", x, y, lat, N + 1);
    end
    n_cmp++;
    if ({obs_carry, obs_sum} !== exp) begin
      n_bad++;
      $display("FAIL rnd_sum %h+%h+%b got %h want %h", x, y, ci, {obs_carry, obs_sum}, exp);
    end
    for (int p = 0; p < N; p++) begin
      pe = exp[W-1:0] & low_mask(p);
      n_cmp++;
      if (obs_part[p] !== pe) begin
        n_bad++;
        $display("FAIL rnd_part%0d %h+%h got %h want %h", p, x, y, obs_part[p], pe);
      end
    end
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
    n_cmp++;
    if (obs_ovf !== ref_ovf(x, y, ci)) begin
      n_bad++;
      $display("FAIL rnd_ovf %h+%h+%b got %b want %b", x, y, ci, obs_ovf, ref_ovf(x, y, ci));
    end
`endif
    finish_op();
  endtask

  task automatic test_random();
    check_one(16'h8000, 16'h8000, 1'b0);
    check_one(16'h7FFF, 16'h0001, 1'b0);
    check_one(16'hFFFF, 16'hFFFF, 1'b1);
    for (int i = 0; i < 2000; i++) begin
      check_one(W'($urandom), W'($urandom), 1'($urandom));
    end
  endtask

`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
  task automatic test_ovf();
    run_op(16'h7FFF, 16'h0001, 1'b0);
    n_cmp++;
    if (obs_ovf !== 1'b1) begin
      n_bad++; $display("FAIL ovf_pos got %b want 1", obs_ovf);
    end
    finish_op();
    run_op(16'h8000, 16'h8000, 1'b0);
    n_cmp++;
    if (obs_ovf !== 1'b1) begin
      n_bad++; $display("FAIL ovf_neg got %b want 1", obs_ovf);
    end
    finish_op();
    run_op(16'h1234, 16'h0101, 1'b1);
    n_cmp++;
    if (obs_ovf !== 1'b0) begin
      n_bad++; $display("FAIL ovf_none got %b want 0", obs_ovf);
    end
    finish_op();
  endtask
`endif

  initial begin
    test_reset();
    test_ripple();
    test_hold_and_ignore();
    test_back_to_back();
    test_reset_abort();
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
    test_ovf();
`endif
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/nibble_serial_adder.md
NIBBLE_SERIAL_ADDER -- requirements
Module: nibble_serial_adder

Interface
REQ-001 SHALL have parameter NIBBLES, default 4, number of 4-bit digits per operand; the operand width W = 4*NIBBLES.
REQ-002 SHALL have port clk  input  1  rising-edge clock, the only clock.
REQ-003 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-004 SHALL have ports a, b  input  W  operands, sampled on input handshake.
REQ-005 SHALL have port cin  input  1  carry-in, sampled on input handshake.
REQ-006 SHALL have port in_valid  input  1  operands valid.
REQ-007 SHALL have port in_ready  output  1  block can accept operands.
REQ-008 SHALL have port sum  output  W  registered result.
REQ-009 SHALL have port carry  output  1  registered carry-out of the top nibble.
REQ-010 SHALL have port out_valid  output  1  result valid.
REQ-011 SHALL have port out_ready  input  1  consumer accepts result.

Function
REQ-012 SHALL implement the FSM states IDLE, BUSY and DONE.
REQ-013 IDLE SHALL drive in_ready=1 and out_valid=0; on in_valid=1 it SHALL latch a, b and cin, clear the nibble index, and go to BUSY.
REQ-014 BUSY SHALL add one nibble per cycle, least-significant nibble first, through one 4-bit ripple-carry adder; the carry SHALL be registered and fed back as the next nibble's carry-in.
REQ-015 BUSY SHALL last exactly NIBBLES cycles, then go to DONE; the index SHALL count from 0 to NIBBLES-1 with no wrap beyond that.
REQ-016 DONE SHALL hold out_valid=1 with sum and carry stable, and SHALL return to IDLE on out_ready=1.
REQ-017 Latency SHALL be NIBBLES+1 clock edges from input handshake to the out_valid rising edge.
REQ-018 in_ready SHALL be 0 in BUSY and DONE; in_valid in those states SHALL be ignored, and operands SHALL NOT be re-sampled.
REQ-019 out_ready while not in DONE SHALL be ignored.
REQ-020 No back-to-back overlap: the earliest next input handshake SHALL be the cycle after the output handshake.
REQ-021 Arithmetic SHALL be unsigned: {carry,sum} = a + b + cin, modulo 2^(W+1), with no truncation of carry.
REQ-022 sum SHALL be built nibble by nibble; nibbles not yet computed SHALL read 0 during BUSY.

Reset
REQ-023 rst_n=0 SHALL immediately force IDLE, sum=0, carry=0, out_valid=0, in_ready=1, index=0 and the internal carry=0.
REQ-024 Reset asserted in BUSY or DONE SHALL abort the operation; no result SHALL be presented after release.
REQ-025 The first input handshake SHALL be possible on the first rising edge after rst_n deasserts.

Configuration
REQ-026 With macro NIBBLE_SERIAL_ADDER_OVF_EN defined, the block SHALL add output port ovf (1 bit), registered in DONE, equal to the signed two's-complement overflow of a+b+cin (carry into MSB XOR carry out of MSB), and reset to 0.
REQ-027 Without NIBBLE_SERIAL_ADDER_OVF_EN, port ovf and its logic SHALL be absent, and all other behaviour SHALL be identical.

Structure
REQ-028 A shared package SHALL hold the FSM state enumeration (IDLE, BUSY, DONE) and the constant NIBBLE_W=4.
REQ-029 The block SHALL instantiate exactly one sub-module, ripple_carry_adder_4bit (ports a, b, cin, sum, carry), as its per-nibble datapath.
REQ-030 Operand shift registers, the index counter and the FSM SHALL live in nibble_serial_adder.

Verification (NIBBLES=4)
REQ-031 a=16'h0001, b=16'h0002, cin=0 -> after 5 edges, out_valid=1, sum=16'h0003, carry=0.
REQ-032 a=16'hFFFF, b=16'h0000, cin=1 -> sum=16'h0000, carry=1; the carry ripples across all 4 nibbles.
REQ-033 Hold out_ready=0 for 10 cycles in DONE -> out_valid stays 1, sum is stable, and in_ready stays 0; with in_valid pulsed mid-BUSY, the result is unchanged.
REQ-034 Assert rst_n=0 in the 2nd BUSY cycle of a=16'h1234 -> all outputs are at reset values, and out_valid never rises for that operation.
REQ-035 Run random exhaustive-style sweep (≥2000 operand sets, including 16'h8000+16'h8000) -> {carry,sum} matches the reference sum; with NIBBLE_SERIAL_ADDER_OVF_EN, 16'h7FFF+16'h0001 gives ovf=1 and 16'h8000+16'h8000 gives ovf=1.
